mfp_reset_sequencer: RTL and testbench



---
 rtl/mfp_reset_sequencer_if.sv | 33 +++
 rtl/mfp_reset_sequencer.sv | 122 ++++++++++++
 tb/tb_mfp_reset_sequencer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_reset_sequencer_if.sv
// Request/status bundle between the board reset sources and the sequencer.
// slave is the sequencer side; master is the requester/observer side.
interface mfp_reset_sequencer_if #(
    parameter int N_CH = 3
);
    logic            ext_reset_req;
    logic            sw_reset_req;
    logic [N_CH-1:0] sw_reset_mask;
    logic [N_CH-1:0] rst_n;
    logic            busy;
    logic            done;
    logic [1:0]      cause;

    modport master (
        output ext_reset_req,
        output sw_reset_req,
        output sw_reset_mask,
        input  rst_n,
        input  busy,
        input  done,
        input  cause
    );

    modport slave (
        input  ext_reset_req,
        input  sw_reset_req,
        input  sw_reset_mask,
        output rst_n,
        output busy,
        output done,
        output cause
    );
endinterface

// File: rtl/mfp_reset_sequencer.sv
// Staggered N_CH-channel reset sequencer (POR / ext / sw causes); all outputs registered, ext seen within SYNC_STAGES+1 edges.
// No backpressure: sw requests outside RUN are dropped, an ext request restarts any sequence.
module mfp_reset_sequencer #(
    parameter int N_CH        = 3,
    parameter int STRETCH     = 16,
    parameter int STAGGER     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    mfp_reset_sequencer_if.slave  bus
);
    localparam int MAX_CNT = (STRETCH > STAGGER) ? STRETCH : STAGGER;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int SLOT_W  = $clog2(N_CH) + 1;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [SLOT_W-1:0]   r_slot;
    logic [N_CH-1:0]     r_rst_n;
    logic                r_busy;
    logic                r_done;
    logic [1:0]          r_cause;
    logic [SYNC_STAGES-1:0] r_ext_sync;
    logic                w_ext;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ext_sync <= '0;
        end else begin
            r_ext_sync <= {r_ext_sync[SYNC_STAGES-2:0], bus.ext_reset_req};
        end
    end

    assign w_ext = r_ext_sync[SYNC_STAGES-1];

    // r_rst_n is loaded with the inverted active set on HOLD entry, so
    // releasing a slot is just setting its bit; inactive slots are already high.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_slot  <= '0;
            r_rst_n <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_cause <= 2'b01;
        end else begin
            r_done <= 1'b0;
            if (w_ext) begin
                r_state <= S_HOLD;
                r_cnt   <= '0;
                r_slot  <= '0;
                r_rst_n <= '0;
                r_busy  <= 1'b1;
                r_cause <= 2'b10;
            end else begin
                case (r_state)
                    S_HOLD: begin
                        if (r_cnt == CNT_W'(STRETCH - 1)) begin
                            r_rst_n[0] <= 1'b1;
                            r_cnt      <= '0;
                            if (N_CH == 1) begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_RELEASE;
                                r_slot  <= SLOT_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_RELEASE: begin
                        if (r_cnt == CNT_W'(STAGGER - 1)) begin
                            r_cnt <= '0;
                            for (int k = 1; k < N_CH; k++) begin
                                if (r_slot == SLOT_W'(k)) begin
                                    r_rst_n[k] <= 1'b1;
                                end
                            end
                            if (r_slot == SLOT_W'(N_CH - 1)) begin
                                r_state <= S_RUN;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_slot <= r_slot + SLOT_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    S_RUN: begin
                        if (bus.sw_reset_req) begin
                            r_state <= S_HOLD;
                            r_cnt   <= '0;
                            r_slot  <= '0;
                            r_rst_n <= ~bus.sw_reset_mask;
                            r_busy  <= 1'b1;
                            r_cause <= 2'b11;
                        end
                    end
                    default: begin
                        r_state <= S_RUN;
                    end
                endcase
            end
        end
    end

    assign bus.rst_n = r_rst_n;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.cause = r_cause;
endmodule

// File: tb/tb_mfp_reset_sequencer.sv
// Bench for mfp_reset_sequencer: release-schedule reference model, directed tables,
// multi-cycle corner sequences and an N_CH=1 instance.
module tb_mfp_reset_sequencer;
    localparam int N    = 3;
    localparam int S    = 16;
    localparam int ST   = 8;
    localparam int SYNC = 2;

    logic HCLK = 1'b0;
    logic HRESETn;
    logic rst1_n;

    always #5 HCLK = ~HCLK;

    mfp_reset_sequencer_if #(.N_CH(N)) bus3 ();
    mfp_reset_sequencer_if #(.N_CH(1)) bus1 ();

    mfp_reset_sequencer #(.N_CH(N), .STRETCH(S), .STAGGER(ST), .SYNC_STAGES(SYNC)) u_dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus3)
    );

    mfp_reset_sequencer #(.N_CH(1), .STRETCH(1), .STAGGER(1), .SYNC_STAGES(2)) u_dut1 (
        .HCLK    (HCLK),
        .HRESETn (rst1_n),
        .bus     (bus1)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a sequence is fully described by its start edge T,
    // its active set and cause; outputs follow from the release schedule.
    int         n;
    int         T;
    logic [2:0] act;
    logic [1:0] mcause;
    bit         ext_q[$];

    typedef struct {
        int         edge_n;
        bit         sw;
        logic [2:0] mask;
        logic [2:0] rst;
        bit         busy;
        bit         done;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[8];

    function automatic int t_end();
        return T + S + (N - 1) * ST;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", name, n, got, exp);
        end
    endtask

    task automatic model_init();
        n      = 0;
        T      = 0;
        act    = 3'b111;
        mcause = 2'b01;
        ext_q.delete();
        for (int i = 0; i < SYNC; i++) ext_q.push_back(1'b0);
    endtask

    task automatic model_check();
        logic [2:0] er;
        er = 3'b111;
        for (int k = 0; k < N; k++) begin
            if (act[k] && (n < T + S + k * ST)) er[k] = 1'b0;
        end
        chk("model_rst_n", 32'(bus3.rst_n), 32'(er));
        chk("model_busy",  32'(bus3.busy),  32'(n < t_end()));
        chk("model_done",  32'(bus3.done),  32'(n == t_end()));
        chk("model_cause", 32'(bus3.cause), 32'(mcause));
    endtask

    task automatic cyc(input bit e, input bit s, input logic [2:0] m);
        bit seen;
        bus3.ext_reset_req = e;
        bus3.sw_reset_req  = s;
        bus3.sw_reset_mask = m;
        @(posedge HCLK);
        n++;
        seen = ext_q.pop_front();
        ext_q.push_back(e);
        if (seen) begin
            T = n; act = 3'b111; mcause = 2'b10;
        end else if (s && (n > t_end())) begin
            T = n; act = m; mcause = 2'b11;
        end
        @(negedge HCLK);
        model_check();
    endtask

    task automatic idle_to(input int target);
        while (n < target) cyc(1'b0, 1'b0, 3'b000);
    endtask

    int ts;
    int e0;
    int dcount;
    int ext_left;
    bit re;
    bit rs;

    initial begin
        vecs[0] = '{15, 1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 2'b01};
        vecs[1] = '{16, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 2'b01};
        vecs[2] = '{20, 1'b1, 3'b111, 3'b001, 1'b1, 1'b0, 2'b01};
        vecs[3] = '{23, 1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 2'b01};
        vecs[4] = '{24, 1'b0, 3'b000, 3'b011, 1'b1, 1'b0, 2'b01};
        vecs[5] = '{31, 1'b0, 3'b000, 3'b011, 1'b1, 1'b0, 2'b01};
        vecs[6] = '{32, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 2'b01};
        vecs[7] = '{33, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 2'b01};

        bus3.ext_reset_req = 1'b0;
        bus3.sw_reset_req  = 1'b0;
        bus3.sw_reset_mask = 3'b000;
        bus1.ext_reset_req = 1'b0;
        bus1.sw_reset_req  = 1'b0;
        bus1.sw_reset_mask = 1'b0;
        HRESETn = 1'b1;
        rst1_n  = 1'b1;
        n = 0;
        #1;
        HRESETn = 1'b0;
        rst1_n  = 1'b0;
        #1;
        // Asynchronous reset values, before any clock edge
        chk("por_rst_n", 32'(bus3.rst_n), 32'd0);
        chk("por_busy",  32'(bus3.busy),  32'd1);
        chk("por_done",  32'(bus3.done),  32'd0);
        chk("por_cause", 32'(bus3.cause), 32'd1);

        repeat (5) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        model_init();

        // POR schedule, including a sw request at edge 20 that must be ignored
        foreach (vecs[i]) begin
            idle_to(vecs[i].edge_n - 1);
            cyc(1'b0, vecs[i].sw, vecs[i].mask);
            chk("tab_rst_n", 32'(bus3.rst_n), 32'(vecs[i].rst));
            chk("tab_busy",  32'(bus3.busy),  32'(vecs[i].busy));
            chk("tab_done",  32'(bus3.done),  32'(vecs[i].done));
            chk("tab_cause", 32'(bus3.cause), 32'(vecs[i].cause));
        end

        // SW masked 3'b101
        idle_to(n + 3);
        cyc(1'b0, 1'b1, 3'b101);
        ts = n;
        chk("sw_start_rst_n", 32'(bus3.rst_n), 32'h2);
        chk("sw_start_busy",  32'(bus3.busy),  32'd1);
        chk("sw_start_cause", 32'(bus3.cause), 32'd3);
        idle_to(ts + 15);
        chk("sw_t15_rst_n", 32'(bus3.rst_n), 32'h2);
        cyc(1'b0, 1'b0, 3'b000);
        chk("sw_t16_rst_n", 32'(bus3.rst_n), 32'h3);
        idle_to(ts + 31);
        chk("sw_t31_rst_n", 32'(bus3.rst_n), 32'h3);
        cyc(1'b0, 1'b0, 3'b000);
        chk("sw_t32_rst_n", 32'(bus3.rst_n), 32'h7);
        chk("sw_t32_done",  32'(bus3.done),  32'd1);
        chk("sw_t32_busy",  32'(bus3.busy),  32'd0);
        cyc(1'b0, 1'b0, 3'b000);
        chk("sw_t33_done",  32'(bus3.done),  32'd0);

        // EXT held for 10 cycles from RUN
        idle_to(n + 3);
        e0 = n + 1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b0, 3'b000);
            if (i == 2) begin
                chk("ext_low_rst_n", 32'(bus3.rst_n), 32'd0);
                chk("ext_low_cause", 32'(bus3.cause), 32'd2);
                chk("ext_low_busy",  32'(bus3.busy),  32'd1);
            end
        end
        idle_to(e0 + 11 + 15);
        chk("ext_t15_rst_n", 32'(bus3.rst_n), 32'd0);
        cyc(1'b0, 1'b0, 3'b000);
        chk("ext_t16_rst_n", 32'(bus3.rst_n), 32'h1);
        idle_to(e0 + 11 + 32);
        chk("ext_t32_rst_n", 32'(bus3.rst_n), 32'h7);
        chk("ext_t32_done",  32'(bus3.done),  32'd1);
        chk("ext_t32_cause", 32'(bus3.cause), 32'd2);

        // EXT preempts a SW sequence mid-HOLD
        idle_to(n + 2);
        cyc(1'b0, 1'b1, 3'b010);
        ts = n;
        chk("pre_sw_rst_n", 32'(bus3.rst_n), 32'h5);
        chk("pre_sw_cause", 32'(bus3.cause), 32'd3);
        idle_to(ts + 4);
        dcount = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 3'b000);
            if (bus3.done) dcount++;
        end
        chk("pre_ext_rst_n", 32'(bus3.rst_n), 32'd0);
        chk("pre_ext_cause", 32'(bus3.cause), 32'd2);
        while (n < ts + 9 + 32 + 5) begin
            cyc(1'b0, 1'b0, 3'b000);
            if (bus3.done) dcount++;
            if (n == ts + 9 + 32) chk("pre_done_edge", 32'(bus3.done), 32'd1);
        end
        chk("pre_done_count", 32'(dcount), 32'd1);

        // Asynchronous reset in the middle of RELEASE
        idle_to(n + 2);
        cyc(1'b0, 1'b1, 3'b111);
        ts = n;
        idle_to(ts + 18);
        chk("arst_pre_rst_n", 32'(bus3.rst_n), 32'h1);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("arst_rst_n", 32'(bus3.rst_n), 32'd0);
        chk("arst_busy",  32'(bus3.busy),  32'd1);
        chk("arst_done",  32'(bus3.done),  32'd0);
        chk("arst_cause", 32'(bus3.cause), 32'd1);
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        model_init();
        idle_to(15);
        chk("arst_e15_rst_n", 32'(bus3.rst_n), 32'd0);
        cyc(1'b0, 1'b0, 3'b000);
        chk("arst_e16_rst_n", 32'(bus3.rst_n), 32'h1);
        idle_to(32);
        chk("arst_e32_rst_n", 32'(bus3.rst_n), 32'h7);
        chk("arst_e32_done",  32'(bus3.done),  32'd1);
        chk("arst_e32_cause", 32'(bus3.cause), 32'd1);

        // Randomised traffic against the reference model
        ext_left = 0;
        for (int i = 0; i < 1500; i++) begin
            re = 1'b0;
            if (ext_left > 0) begin
                re = 1'b1;
                ext_left--;
            end else if ($urandom_range(0, 99) < 2) begin
                ext_left = $urandom_range(1, 12);
            end
            rs = ($urandom_range(0, 14) == 0);
            cyc(re, rs, 3'($urandom_range(0, 7)));
        end
        bus3.ext_reset_req = 1'b0;
        bus3.sw_reset_req  = 1'b0;

        // N_CH=1, STRETCH=1, STAGGER=1 instance
        @(negedge HCLK);
        chk("n1_por_rst_n", 32'(bus1.rst_n), 32'd0);
        chk("n1_por_busy",  32'(bus1.busy),  32'd1);
        chk("n1_por_cause", 32'(bus1.cause), 32'd1);
        rst1_n = 1'b1;
        @(negedge HCLK);
        chk("n1_e1_rst_n", 32'(bus1.rst_n), 32'd1);
        chk("n1_e1_done",  32'(bus1.done),  32'd1);
        chk("n1_e1_busy",  32'(bus1.busy),  32'd0);
        @(negedge HCLK);
        chk("n1_e2_done",  32'(bus1.done),  32'd0);
        bus1.sw_reset_req  = 1'b1;
        bus1.sw_reset_mask = 1'b1;
        @(negedge HCLK);
        bus1.sw_reset_req  = 1'b0;
        chk("n1_sw_rst_n", 32'(bus1.rst_n), 32'd0);
        chk("n1_sw_busy",  32'(bus1.busy),  32'd1);
        chk("n1_sw_cause", 32'(bus1.cause), 32'd3);
        @(negedge HCLK);
        chk("n1_sw_end_rst_n", 32'(bus1.rst_n), 32'd1);
        chk("n1_sw_end_done",  32'(bus1.done),  32'd1);
        #2;
        rst1_n = 1'b0;
        #1;
        chk("n1_arst_rst_n", 32'(bus1.rst_n), 32'd0);
        chk("n1_arst_cause", 32'(bus1.cause), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
